// File: rtl/vga_dash_line_gen.sv
// Dashed vertical/horizontal line overlay composited onto the VGA pixel stream.
// One registered stage: RGB and syncs leave exactly one cycle after they arrive.
module vga_dash_line_gen #(
  parameter int         H_ACTIVE    = 640,
  parameter int         V_ACTIVE    = 480,
  parameter int         ORIENT      = 0,
  parameter int         LINE_POS    = 319,
  parameter int         LINE_THICK  = 2,
  parameter int         DASH_LEN    = 5,
  parameter int         GAP_LEN     = 5,
  parameter int         SCROLL_STEP = 1,
  parameter logic [8:0] FG_COLOR    = 9'h1FF
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_enable,
  input  logic       i_scroll_en,
  input  logic       i_hSync,
  input  logic       i_vSync,
  input  logic [9:0] i_display_x_pos,
  input  logic [9:0] i_display_y_pos,
  input  logic [2:0] i_red,
  input  logic [2:0] i_green,
  input  logic [2:0] i_blue,
  output logic [2:0] o_red,
  output logic [2:0] o_green,
  output logic [2:0] o_blue,
  output logic       o_hSync,
  output logic       o_vSync
);

  localparam int P     = DASH_LEN + GAP_LEN;
  localparam int OFF_W = $clog2(P);

  logic [OFF_W-1:0] r_offset;
  logic [9:0]       r_prev_y;

  logic [9:0]       w_a;
  logic [9:0]       w_c;
  logic [10:0]      w_sum;
  logic [10:0]      w_phase;
  logic             w_dash_on;
  logic             w_on_line;
  logic             w_active;
  logic             w_frame_edge;
  logic [OFF_W:0]   w_off_sum;
  logic [OFF_W-1:0] w_off_next;
  logic [8:0]       w_pix;

  always_comb begin
    w_a          = i_display_y_pos;
    w_c          = i_display_x_pos;
    w_sum        = 11'd0;
    w_phase      = 11'd0;
    w_dash_on    = 1'b0;
    w_on_line    = 1'b0;
    w_active     = 1'b0;
    w_frame_edge = 1'b0;
    w_off_sum    = '0;
    w_off_next   = r_offset;
    w_pix        = {i_red, i_green, i_blue};

    if (ORIENT != 0) begin
      w_a = i_display_x_pos;
      w_c = i_display_y_pos;
    end else begin
      w_a = i_display_y_pos;
      w_c = i_display_x_pos;
    end

    // Divider by a small constant period keeps the dash phase exact at every pixel.
    w_sum     = {1'b0, w_a} + 11'(r_offset);
    w_phase   = w_sum % 11'(P);
    w_dash_on = (w_phase < 11'(DASH_LEN));
    w_on_line = ({1'b0, w_c} >= 11'(LINE_POS)) &&
                ({1'b0, w_c} <  11'(LINE_POS + LINE_THICK));
    w_active  = ({1'b0, i_display_x_pos} < 11'(H_ACTIVE)) &&
                ({1'b0, i_display_y_pos} < 11'(V_ACTIVE));

    w_frame_edge = (r_prev_y == 10'(V_ACTIVE - 1)) &&
                   (i_display_y_pos == 10'(V_ACTIVE));

    w_off_sum = (OFF_W+1)'(r_offset) + (OFF_W+1)'(SCROLL_STEP);
    if (w_off_sum >= (OFF_W+1)'(P)) begin
      w_off_next = OFF_W'(w_off_sum - (OFF_W+1)'(P));
    end else begin
      w_off_next = OFF_W'(w_off_sum);
    end

    if (!w_active) begin
      w_pix = 9'h000;
    end else if (i_enable && w_on_line && w_dash_on) begin
      w_pix = FG_COLOR;
    end else begin
      w_pix = {i_red, i_green, i_blue};
    end
  end

  // Offset only moves at the bottom-of-frame transition, so it is stable across the active area.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      o_red    <= 3'd0;
      o_green  <= 3'd0;
      o_blue   <= 3'd0;
      o_hSync  <= 1'b1;
      o_vSync  <= 1'b1;
      r_offset <= '0;
      r_prev_y <= 10'd0;
    end else begin
      {o_red, o_green, o_blue} <= w_pix;
      o_hSync  <= i_hSync;
      o_vSync  <= i_vSync;
      r_prev_y <= i_display_y_pos;
      if (w_frame_edge && i_scroll_en) begin
        r_offset <= w_off_next;
      end else begin
        r_offset <= r_offset;
      end
    end
  end

endmodule

// File: tb/tb_vga_dash_line_gen.sv
// Self-checking bench for vga_dash_line_gen: directed scenarios plus randomized
// traffic compared against a frame-counting behavioural model.
module tb_vga_dash_line_gen;

  logic       clk = 1'b0;
  logic       rst_n, en, sc, hs, vs;
  logic [9:0] x, y;
  logic [2:0] r, g, b;
  logic [2:0] o0_r, o0_g, o0_b, o1_r, o1_g, o1_b;
  logic       o0_h, o0_v, o1_h, o1_v;

  int         checks   = 0;
  int         failures = 0;
  int         model_off;
  int         model_prev_y;
  logic [8:0] last0, last1;

  localparam logic [8:0] WHITE = 9'h1FF;
  localparam logic [8:0] BG2   = 9'b010_010_010;

  always #5 clk = ~clk;

  vga_dash_line_gen dut0 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_enable(en), .i_scroll_en(sc),
    .i_hSync(hs), .i_vSync(vs), .i_display_x_pos(x), .i_display_y_pos(y),
    .i_red(r), .i_green(g), .i_blue(b),
    .o_red(o0_r), .o_green(o0_g), .o_blue(o0_b), .o_hSync(o0_h), .o_vSync(o0_v)
  );

  vga_dash_line_gen #(.ORIENT(1), .LINE_POS(240), .LINE_THICK(1)) dut1 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_enable(en), .i_scroll_en(sc),
    .i_hSync(hs), .i_vSync(vs), .i_display_x_pos(x), .i_display_y_pos(y),
    .i_red(r), .i_green(g), .i_blue(b),
    .o_red(o1_r), .o_green(o1_g), .o_blue(o1_b), .o_hSync(o1_h), .o_vSync(o1_v)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference pixel straight from the overlay rules.
  function automatic logic [8:0] ref_pix(input int orient, input int pos, input int thick,
                                         input int xx, input int yy, input logic [8:0] bg,
                                         input logic e, input int off);
    int a, c;
    if (xx >= 640 || yy >= 480) return 9'h000;
    a = (orient != 0) ? xx : yy;
    c = (orient != 0) ? yy : xx;
    if (e && c >= pos && c < pos + thick && ((a + off) % 10) < 5) return WHITE;
    return bg;
  endfunction

  task automatic cycle(input string tag, input logic rn, input int xx, input int yy,
                       input logic [8:0] bg, input logic e, input logic s,
                       input logic h, input logic v);
    logic [8:0] e0, e1;
    rst_n = rn; x = 10'(xx); y = 10'(yy); {r, g, b} = bg;
    en = e; sc = s; hs = h; vs = v;
    if (!rn) begin
      e0 = 9'h000;
      e1 = 9'h000;
    end else begin
      e0 = ref_pix(0, 319, 2, xx, yy, bg, e, model_off);
      e1 = ref_pix(1, 240, 1, xx, yy, bg, e, model_off);
    end
    @(posedge clk); #1;
    last0 = {o0_r, o0_g, o0_b};
    last1 = {o1_r, o1_g, o1_b};
    check_eq({tag, "_pix0"}, last0, e0);
    check_eq({tag, "_pix1"}, last1, e1);
    check_eq({tag, "_hs0"}, o0_h, rn ? h : 1'b1);
    check_eq({tag, "_vs0"}, o0_v, rn ? v : 1'b1);
    check_eq({tag, "_hs1"}, o1_h, rn ? h : 1'b1);
    check_eq({tag, "_vs1"}, o1_v, rn ? v : 1'b1);
    if (!rn) begin
      model_off    = 0;
      model_prev_y = 0;
    end else begin
      if (model_prev_y == 479 && yy == 480 && s) model_off = (model_off + 1) % 10;
      model_prev_y = yy;
    end
  endtask

  task automatic frame_edge(input logic s);
    cycle("fe_a", 1'b1, 0, 479, BG2, 1'b1, s, 1'b1, 1'b1);
    cycle("fe_b", 1'b1, 0, 480, BG2, 1'b1, s, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    cycle("rst", 1'b0, 0, 0, BG2, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle("rst", 1'b0, 0, 0, BG2, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_off    = 0;
    model_prev_y = 0;
    do_reset();
    check_eq("reset_rgb", last0, 9'h000);
    check_eq("reset_hs", o0_h, 1'b1);

    // Vertical dash pattern down x=319.
    for (int i = 0; i < 10; i++) begin
      cycle("t1", 1'b1, 319, i, BG2, 1'b1, 1'b0, 1'b1, 1'b1);
      check_eq("t1_const", last0, (i < 5) ? WHITE : BG2);
    end

    // Cross-axis edges and enable.
    cycle("t2", 1'b1, 318, 0, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t2_x318", last0, BG2);
    cycle("t2", 1'b1, 319, 0, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t2_x319", last0, WHITE);
    cycle("t2", 1'b1, 320, 0, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t2_x320", last0, WHITE);
    cycle("t2", 1'b1, 321, 0, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t2_x321", last0, BG2);
    cycle("t2", 1'b1, 319, 0, BG2, 1'b0, 1'b0, 1'b1, 1'b1); check_eq("t2_dis", last0, BG2);

    // Horizontal instance along y=240.
    for (int i = 0; i < 10; i++) begin
      cycle("t4", 1'b1, i, 240, BG2, 1'b1, 1'b0, 1'b1, 1'b1);
      check_eq("t4_const", last1, (i < 5) ? WHITE : BG2);
    end
    cycle("t4", 1'b1, 0, 239, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t4_y239", last1, BG2);
    cycle("t4", 1'b1, 0, 241, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t4_y241", last1, BG2);

    // Blanking and sync delay.
    cycle("t5", 1'b1, 640, 0, WHITE, 1'b1, 1'b0, 1'b0, 1'b1); check_eq("t5_xblank", last0, 9'h000);
    check_eq("t5_hs_low", o0_h, 1'b0);
    cycle("t5", 1'b1, 0, 480, WHITE, 1'b1, 1'b0, 1'b1, 1'b0); check_eq("t5_yblank", last0, 9'h000);
    check_eq("t5_vs_low", o0_v, 1'b0);

    // Scroll by three frames, then hold, then wrap after ten.
    do_reset();
    repeat (3) frame_edge(1'b1);
    cycle("t3", 1'b1, 319, 0, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t3_y0", last0, WHITE);
    cycle("t3", 1'b1, 319, 2, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t3_y2", last0, BG2);
    cycle("t3", 1'b1, 319, 7, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t3_y7", last0, WHITE);
    frame_edge(1'b0);
    cycle("t3h", 1'b1, 319, 2, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t3h_y2", last0, BG2);
    cycle("t3h", 1'b1, 319, 7, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t3h_y7", last0, WHITE);
    repeat (7) frame_edge(1'b1);
    cycle("t3w", 1'b1, 319, 0, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t3w_y0", last0, WHITE);
    cycle("t3w", 1'b1, 319, 5, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t3w_y5", last0, BG2);
    cycle("t3w", 1'b1, 319, 9, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t3w_y9", last0, BG2);

    // Mid-frame reset with offset 4.
    repeat (4) frame_edge(1'b1);
    cycle("t6", 1'b1, 319, 6, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t6_off4", last0, WHITE);
    cycle("t6", 1'b0, 319, 100, BG2, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t6_rst_rgb", last0, 9'h000);
    check_eq("t6_rst_hs", o0_h, 1'b1);
    cycle("t6", 1'b1, 319, 0, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t6_after", last0, WHITE);
    cycle("t6", 1'b1, 319, 6, BG2, 1'b1, 1'b0, 1'b1, 1'b1); check_eq("t6_after6", last0, BG2);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int rx, ry;
      if ($urandom_range(0, 19) == 0) begin
        frame_edge(1'($urandom_range(0, 1)));
      end else begin
        rx = ($urandom_range(0, 1) == 1) ? $urandom_range(314, 324) : $urandom_range(0, 700);
        ry = ($urandom_range(0, 1) == 1) ? $urandom_range(235, 245) : $urandom_range(0, 520);
        cycle("rnd", ($urandom_range(0, 199) != 0), rx, ry, 9'($urandom),
              ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_dash_line_gen.md
Name: vga_dash_line_gen

Overview:
Parametrised dashed-line overlay for the VGA pixel pipeline. It draws a vertical or horizontal dashed line with configurable position, thickness, dash and gap lengths, and colour. The line is composited over an incoming background pixel stream, and the dash pattern can optionally scroll by a fixed step each frame. It sits between the pixel-coordinate generator / upstream renderers and the VGA output, adding one cycle of latency to RGB and syncs.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
ORIENT, 0, 0 = vertical line (pattern runs along y); 1 = horizontal line (pattern runs along x)
LINE_POS, 319, first cross-axis coordinate of the line (x if ORIENT=0, y if ORIENT=1)
LINE_THICK, 2, line thickness in pixels; covers LINE_POS .. LINE_POS+LINE_THICK-1
DASH_LEN, 5, lit pixels per period (>=1)
GAP_LEN, 5, unlit pixels per period (>=1); P = DASH_LEN+GAP_LEN, P <= 64
SCROLL_STEP, 1, pattern advance per frame when scrolling; 0 <= SCROLL_STEP < P
FG_COLOR, 9'h1FF, line colour {r[2:0],g[2:0],b[2:0]}

Ports:
i_CLK  in  1  pixel clock
i_RST_N  in  1  synchronous active-low reset
i_enable  in  1  1 = draw line; 0 = pure pass-through
i_scroll_en  in  1  1 = advance offset at each frame edge
i_hSync  in  1  horizontal sync, aligned with coordinates
i_vSync  in  1  vertical sync, aligned with coordinates
i_display_x_pos  in  10  current pixel x
i_display_y_pos  in  10  current pixel y
i_red / i_green / i_blue  in  3 each  background pixel, aligned with coordinates
o_red / o_green / o_blue  out  3 each  composited pixel
o_hSync / o_vSync  out  1 each  syncs delayed to match RGB

Behaviour:
- Reset (i_RST_N=0 at a clock edge): o_red/o_green/o_blue=0, o_hSync=o_vSync=1, offset=0, frame-edge detector cleared. Reset asserted mid-frame takes effect at the next edge; output resumes the cycle after release, with offset 0.
- Latency: exactly 1 cycle from inputs to all outputs. Syncs are registered copies of the inputs.
- Axes: along-axis a = y (ORIENT=0) or x (ORIENT=1); cross-axis c = the other coordinate.
- Dash test: dash_on = ((a + offset) mod P) < DASH_LEN. The implementation may use a phase counter instead of a divider, but the result must equal this formula for every a in the active area, including the first pixel of each line or frame.
- Pixel select, registered at each edge:
  - x >= H_ACTIVE or y >= V_ACTIVE: black (0,0,0).
  - Otherwise, if i_enable, c in [LINE_POS, LINE_POS+LINE_THICK-1], and dash_on: FG_COLOR.
  - Otherwise: pass i_red/i_green/i_blue through.
- Line clipping: a line extending past the active edge is clipped. Dashes are truncated at the screen edge; no wrap onto the next line or frame.
- Frame edge: detected when y changes from V_ACTIVE-1 to V_ACTIVE, using the registered previous y. Exactly one event per frame.
  - At a frame edge with i_scroll_en=1: offset <= (offset + SCROLL_STEP) mod P.
  - With i_scroll_en=0: offset holds.
  - The new offset applies from the next frame's y=0. It never changes inside the active area.
- Offset register width: ceil(log2(P)) bits. It always stays in 0..P-1.
- i_enable and i_scroll_en are sampled each cycle. Toggling i_enable mid-frame affects only pixels from that cycle onward.

Test Plan:
1. Defaults, offset 0, x=319, y=0..9, background 3'b010 on all channels -> y=0..4 output 3'b111 on all channels; y=5..9 output 3'b010; each result appears 1 cycle after its input.
2. Cross-axis edges: x=318 and x=321 at y=0 -> background passed through; x=319 and x=320 -> white. i_enable=0 at x=319, y=0 -> background.
3. Scroll: three frame edges with i_scroll_en=1 -> offset=3; next frame at x=319: y=0 white, y=2 background, y=7 white. With i_scroll_en=0 for a further frame edge, offset stays 3. After 10 frame edges from reset with scrolling enabled, offset wraps to 0.
4. ORIENT=1, LINE_POS=240, LINE_THICK=1: y=240, x=0..9 -> x=0..4 white, x=5..9 background; y=239 and y=241 -> background.
5. Blanking: x=640 or y=480 with a white background -> black. Toggle i_hSync/i_vSync -> o_hSync/o_vSync follow exactly 1 cycle later.
6. Reset mid-frame with offset=4 -> next cycle outputs 0 and syncs 1; after release, at x=319, y=0 -> white (offset 0).
